data_mem_responder: RTL and testbench

- Memory-side responder for the load/store path of the 32-bit core. It accepts one request at a time from the execute stage and stores byte, halfword or word data into an internal word array.
- For loads it returns the selected byte or halfword left-justified on memData; the execute stage then sign- or zero-extends it.
- Fixed access latency, valid/ready request handshake, one-cycle response pulse.

---
 rtl/data_mem_responder.sv | 162 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - load/store memory responder with fixed access latency
//
// Accepts one load/store request at a time, waits LATENCY cycles, performs the
// access on an internal big-endian word array and pulses resp_valid for one cycle.
// Optional macro DMEM_ALIGN_CHECK_EN: flag misaligned H/W accesses on resp_fault
// instead of silently dropping the low address bits.
//
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   req_valid/ready   request handshake
//   req_we            1 = store, 0 = load
//   req_funct3        access size (B/H/W, BU/HU treated as B/H, others as W)
//   req_addr          byte address (wraps modulo 4*DEPTH)
//   req_wdata         store data, low bits used
//   req_rd            tag echoed on resp_rd
//   resp_valid        one-cycle completion pulse
//   resp_rd           tag of completed request
//   memData           load result, left-justified, held until next load response
//   resp_fault        misaligned access flag (always 0 without the macro)
module data_mem_responder #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            resp_valid,
  output logic [4:0]      resp_rd,
  output logic [31:0]     memData,
  output logic            resp_fault
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t         state, state_nxt;
  logic [3:0]     cnt;
  logic           we_q;
  logic [1:0]     size_q;
  logic [AW+1:0]  addr_q;
  logic [31:0]    wdata_q;
  logic [4:0]     rd_q;
  logic           fault_q;

  logic [31:0]    mem [DEPTH];

  logic           access_now;
  logic [AW-1:0]  idx;
  logic [1:0]     off;
  logic           is_b, is_h, is_w;
  logic           misaligned;
  logic [31:0]    word, load_val, lane_mask, lane_data;

  // funct3[2] only distinguishes unsigned variants, which the execute stage handles.
  logic           unused_bits;
  assign unused_bits = ^{req_funct3[2], req_addr[XLEN-1:AW+2]};

  assign access_now = (state == ACCESS) && (cnt == 4'd0);
  assign idx        = addr_q[AW+1:2];
  assign off        = addr_q[1:0];
  assign is_b       = (size_q == 2'b00);
  assign is_h       = (size_q == 2'b01);
  assign is_w       = size_q[1];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = (is_h && off[0]) || (is_w && (off != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Big-endian lanes: offset 0 is the MSB byte, so loads shift left to justify
  // and store masks shift right from the top of the word. H uses only off[1]
  // and W uses no offset, which drops the sub-size address bits.
  always_comb begin
    word      = mem[idx];
    load_val  = word;
    lane_mask = 32'hFFFF_FFFF;
    lane_data = wdata_q;
    if (is_b) begin
      load_val  = (word << {off, 3'b000}) & 32'hFF00_0000;
      lane_mask = 32'hFF00_0000 >> {off, 3'b000};
      lane_data = {wdata_q[7:0], 24'h0} >> {off, 3'b000};
    end else if (is_h) begin
      load_val  = (word << {off[1], 4'h0}) & 32'hFFFF_0000;
      lane_mask = 32'hFFFF_0000 >> {off[1], 4'h0};
      lane_data = {wdata_q[15:0], 16'h0} >> {off[1], 4'h0};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rd_q    <= 5'd0;
      resp_rd <= 5'd0;
      memData <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        size_q  <= req_funct3[1:0];
        addr_q  <= req_addr[AW+1:0];
        wdata_q <= req_wdata[31:0];
        rd_q    <= req_rd;
        cnt     <= 4'(LATENCY - 1);
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access_now) begin
        resp_rd <= rd_q;
        fault_q <= misaligned;
        if (!we_q) memData <= misaligned ? 32'h0 : load_val;
      end
    end
  end

  // Array is deliberately not cleared by reset; a reset before the commit
  // cycle aborts the store because access_now is gated by reset here.
  always_ff @(posedge clk) begin
    if (reset && access_now && we_q && !misaligned)
      mem[idx] <= (word & ~lane_mask) | (lane_data & lane_mask);
  end

  assign resp_fault = fault_q & resp_valid;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [4:0]  req_rd = 5'd0;
  logic        resp_valid;
  logic [4:0]  resp_rd;
  logic [31:0] memData;
  logic        resp_fault;

  data_mem_responder #(.XLEN(32), .DEPTH(256), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .resp_valid(resp_valid),
    .resp_rd(resp_rd), .memData(memData), .resp_fault(resp_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        fault;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_md = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("resp_rd", {27'h0, resp_rd}, {27'h0, e.rd});
        check("memData", memData, e.data);
        check("resp_fault", {31'h0, resp_fault}, {31'h0, e.fault});
        check("latency", 32'(cyc - e.acc), 32'(LAT));
      end
    end
  end

  // Called on a negedge; returns on the negedge after acceptance with
  // req_valid still high so consecutive calls exercise a held request.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] exp_data, input logic exp_fault);
    exp_t e;
    int n;
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", {31'h0, req_ready}, 32'd1);
    end else begin
      e.rd = rd;
      e.fault = exp_fault;
      if (we) e.data = last_md;
      else begin
        e.data = exp_data;
        last_md = exp_data;
      end
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    req_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_pending", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check("rst_req_ready", {31'h0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    check("rst_memData", memData, 32'h0);
    check("rst_resp_fault", {31'h0, resp_fault}, 32'd0);

    do_req(1'b1, 3'b010, 32'h10, 32'hA1B2C3D4, 5'd1, 32'h0, 1'b0);
    drain();
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd2, 32'hA1B2C3D4, 1'b0);
    drain();

    do_req(1'b1, 3'b000, 32'h11, 32'hFFFFFF55, 5'd3, 32'h0, 1'b0);
    drain();
    do_req(1'b0, 3'b000, 32'h11, 32'h0, 5'd4, 32'h55000000, 1'b0);
    drain();
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd5, 32'hA155C3D4, 1'b0);
    drain();
    do_req(1'b0, 3'b001, 32'h12, 32'h0, 5'd6, 32'hC3D40000, 1'b0);
    drain();
    do_req(1'b0, 3'b101, 32'h10, 32'h0, 5'd7, 32'hA1550000, 1'b0);
    drain();
    do_req(1'b0, 3'b100, 32'h13, 32'h0, 5'd8, 32'hD4000000, 1'b0);
    drain();
    do_req(1'b0, 3'b010, 32'h410, 32'h0, 5'd9, 32'hA155C3D4, 1'b0);
    drain();
    do_req(1'b0, 3'b011, 32'h10, 32'h0, 5'd10, 32'hA155C3D4, 1'b0);
    drain();

    do_req(1'b1, 3'b010, 32'h20, 32'h11223344, 5'd11, 32'h0, 1'b0);
    do_req(1'b1, 3'b001, 32'h22, 32'hFFFFBEEF, 5'd12, 32'h0, 1'b0);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 5'd13, 32'h1122BEEF, 1'b0);
    do_req(1'b1, 3'b000, 32'h20, 32'h00000099, 5'd14, 32'h0, 1'b0);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 5'd15, 32'h9922BEEF, 1'b0);
    do_req(1'b0, 3'b001, 32'h20, 32'h0, 5'd16, 32'h99220000, 1'b0);
    drain();

    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd17, 32'h0, 1'b0);
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    last_md = 32'h0;
    check("abort_req_ready", {31'h0, req_ready}, 32'd1);
    check("abort_resp_valid", {31'h0, resp_valid}, 32'd0);
    check("abort_memData", memData, 32'h0);
    repeat (4) @(negedge clk);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd18, 32'hA155C3D4, 1'b0);
    drain();

`ifdef DMEM_ALIGN_CHECK_EN
    do_req(1'b1, 3'b010, 32'h13, 32'h12345678, 5'd19, 32'h0, 1'b1);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd20, 32'hA155C3D4, 1'b0);
    do_req(1'b0, 3'b010, 32'h13, 32'h0, 5'd21, 32'h0, 1'b1);
    do_req(1'b0, 3'b001, 32'h11, 32'h0, 5'd22, 32'h0, 1'b1);
    do_req(1'b0, 3'b000, 32'h13, 32'h0, 5'd23, 32'hD4000000, 1'b0);
`else
    do_req(1'b1, 3'b010, 32'h13, 32'h12345678, 5'd19, 32'h0, 1'b0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd20, 32'h12345678, 1'b0);
    do_req(1'b0, 3'b001, 32'h11, 32'h0, 5'd21, 32'h12340000, 1'b0);
    do_req(1'b0, 3'b000, 32'h13, 32'h0, 5'd22, 32'h78000000, 1'b0);
`endif
    drain();
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
